// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: mul/div opcode encodings, sequencer
// state enum, and the R-type funct codes the decoder uses to raise Start
// and ReadReq.
package mips_pkg;

  // Op encodings driven by the Controller into the mul/div unit.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Sequencer states.
  typedef enum logic [2:0] {
    MD_IDLE  = 3'd0,
    MD_PREP  = 3'd1,
    MD_RUN   = 3'd2,
    MD_FIXUP = 3'd3,
    MD_DONE  = 3'd4
  } md_state_t;

  // R-type funct field values for HI/LO access and mul/div.
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared mul/div datapath on an unsigned 2*WIDTH+1
// accumulator. Multiply: {carry, hi, lo} shift-add, multiplier in lo.
// Divide: {rem, quotient} restoring shift-subtract, dividend in lo.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  i_acc,
  input  logic [WIDTH-1:0]  i_operand,
  input  logic              i_is_div,
  output logic [2*WIDTH:0]  o_acc
);

  logic [WIDTH:0] w_mul_sum;
  logic [WIDTH:0] w_div_top;
  logic [WIDTH:0] w_div_diff;
  logic           w_div_ge;

  // Single combinational step; both paths computed, mode selects.
  always_comb begin
    // Multiply: add the multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    w_mul_sum  = i_acc[2*WIDTH:WIDTH] + (i_acc[0] ? {1'b0, i_operand} : '0);
    // Divide: shift {rem, quotient} left, try to subtract the divisor,
    // keep the difference only when it does not underflow.
    w_div_top  = i_acc[2*WIDTH-1:WIDTH-1];
    w_div_ge   = (w_div_top >= {1'b0, i_operand});
    w_div_diff = w_div_top - {1'b0, i_operand};
    if (i_is_div) begin
      o_acc = {(w_div_ge ? w_div_diff : w_div_top), i_acc[WIDTH-2:0], w_div_ge};
    end else begin
      o_acc = {1'b0, w_mul_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO. Latches operands on
// Start, takes magnitudes, iterates one bit per cycle through muldiv_step,
// applies result signs and commits HI/LO. Stalls the front of the pipeline
// while a mfhi/mflo or another mul/div waits on a busy unit.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             ReadReq,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t        r_state, w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_operand, r_hi, r_lo;
  logic [2*WIDTH:0] r_acc, w_step_acc;
  logic             r_neg_q, r_neg_r, r_dbz;

  logic             w_accept, w_load, w_step, w_commit;
  logic             w_is_div, w_signed, w_b_zero;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot, w_rem;

  assign w_is_div = (r_op == MD_DIV) || (r_op == MD_DIVU);
  assign w_signed = (r_op == MD_MULT) || (r_op == MD_DIV);
  assign w_b_zero = (r_b == '0);
  assign w_abs_a  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_abs_b  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  // Sign fixup of the finished accumulator.
  assign w_prod = r_neg_q ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
  assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .i_is_div  (w_is_div),
    .o_acc     (w_step_acc)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (Reset) r_state <= MD_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state, datapath control strobes and status outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first; a branch that
    // skips an assignment would otherwise infer a latch.
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_commit     = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (Start && !Flush) begin
          w_accept     = 1'b1;
          w_next_state = MD_PREP;
        end
      end
      MD_PREP: begin
        Busy = 1'b1;
        if (Flush) begin
          w_next_state = MD_IDLE;
        end else begin
          w_load       = 1'b1;
          w_next_state = (w_is_div && w_b_zero) ? MD_DONE : MD_RUN;
        end
      end
      MD_RUN: begin
        Busy = 1'b1;
        if (Flush) begin
          w_next_state = MD_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CW'(1)) w_next_state = MD_FIXUP;
        end
      end
      MD_FIXUP: begin
        Busy = 1'b1;
        if (Flush) begin
          w_next_state = MD_IDLE;
        end else begin
          w_commit     = 1'b1;
          w_next_state = MD_DONE;
        end
      end
      MD_DONE: begin
        Done = 1'b1;
        if (Start && !Flush) begin
          w_accept     = 1'b1;
          w_next_state = MD_PREP;
        end else begin
          w_next_state = MD_IDLE;
        end
      end
      default: w_next_state = MD_IDLE;
    endcase
  end

  assign Stall     = Busy && (ReadReq || Start);
  assign DivByZero = Done && r_dbz;
  assign Hi        = r_hi;
  assign Lo        = r_lo;

  // Operand capture, iteration datapath, counter and HI/LO commit.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: the datapath registers are reset as well so no X can ever
    // propagate into HI/LO, even if a reset lands mid-operation.
    if (Reset) begin
      r_op      <= MD_MULT;
      r_a       <= '0;
      r_b       <= '0;
      r_operand <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= Op;
        r_a   <= A;
        r_b   <= B;
        r_dbz <= 1'b0;
      end
      if (w_load) begin
        // Multiply: multiplier |B| in lo, multiplicand |A| added above.
        // Divide: dividend |A| in lo, divisor |B| subtracted above.
        r_acc     <= w_is_div ? {1'b0, {WIDTH{1'b0}}, w_abs_a}
                              : {1'b0, {WIDTH{1'b0}}, w_abs_b};
        r_operand <= w_is_div ? w_abs_b : w_abs_a;
        r_cnt     <= CW'(WIDTH);
        r_neg_q   <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        r_neg_r   <= w_signed && r_a[WIDTH-1];
        r_dbz     <= w_is_div && w_b_zero;
      end
      if (w_step) begin
        r_acc <= w_step_acc;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_commit) begin
        if (w_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end else begin
          {r_hi, r_lo} <= w_prod;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases, stall/flush/
// reset scenarios, then random operations against an arithmetic model.
module tb_muldiv_sequencer;
  import mips_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, Flush, ReadReq;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Stall, Done, DivByZero;
  logic [31:0] Hi, Lo;

  int n_tests = 0;
  int n_fail  = 0;

  // Model copy of the architectural HI/LO registers.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .ReadReq(ReadReq), .Busy(Busy), .Stall(Stall),
    .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of one mul/div given the previous HI/LO.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] ph, input logic [31:0] pl,
                                    output logic [31:0] hi, output logic [31:0] lo,
                                    output logic dbz);
    longint      p;
    logic [63:0] up;
    int          sa, sb;
    dbz = 1'b0;
    hi  = ph;
    lo  = pl;
    sa  = a;
    sb  = b;
    case (op)
      MD_MULT: begin
        p = longint'(sa) * longint'(sb);
        {hi, lo} = p;
      end
      MD_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {hi, lo} = up;
      end
      MD_DIV: begin
        if (b == 0) dbz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'h0;
        end else begin
          lo = sa / sb;
          hi = sa % sb;
        end
      end
      default: begin
        if (b == 0) dbz = 1'b1;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // Present an op for one edge; returns in cycle 1 (just after edge 0).
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Follow an accepted op from cycle first_cyc to its Done cycle, checking
  // Busy, Stall, HI/LO hold, latency and result. ReadReq is raised from
  // cycle rr_from (0 = never). Returns inside the Done cycle.
  task automatic finish_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int first_cyc, input int rr_from, input string tag);
    logic [31:0] eh, el;
    logic        edbz;
    int          cyc;
    int          exp_lat;
    ref_model(op, a, b, m_hi, m_lo, eh, el, edbz);
    exp_lat = edbz ? 2 : 35;
    cyc = first_cyc;
    while (cyc <= 80) begin
      if (rr_from != 0 && cyc >= rr_from) ReadReq = 1'b1;
      #1;
      if (Done) break;
      check({tag, "_busy"}, 64'(Busy), 64'(1));
      check({tag, "_stall"}, 64'(Stall), 64'(ReadReq));
      check({tag, "_hold"}, {Hi, Lo}, {m_hi, m_lo});
      @(negedge Clk);
      cyc++;
    end
    check({tag, "_done"}, 64'(Done), 64'(1));
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_dbz"}, 64'(DivByZero), 64'(edbz));
    check({tag, "_busy_done"}, 64'(Busy), 64'(0));
    check({tag, "_stall_done"}, 64'(Stall), 64'(0));
    check({tag, "_hi"}, 64'(Hi), 64'(eh));
    check({tag, "_lo"}, 64'(Lo), 64'(el));
    ReadReq = 1'b0;
    m_hi = eh;
    m_lo = el;
  endtask

  // Complete op followed by a check that Done was a single-cycle pulse.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    start_op(op, a, b);
    finish_op(op, a, b, 1, 0, tag);
    @(negedge Clk);
    #1;
    check({tag, "_pulse"}, {63'(Busy), Done}, 64'(0));
    check({tag, "_keep"}, {Hi, Lo}, {m_hi, m_lo});
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          done_seen;

    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; ReadReq = 1'b0;
    Op = MD_MULT; A = '0; B = '0;
    #1;
    check("reset_outputs", {58'(0), Busy, Stall, Done, DivByZero, 2'b00}, 64'(0));
    check("reset_hilo", {Hi, Lo}, 64'(0));
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // 1..4: directed arithmetic cases.
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,        "mult_neg3x7");
    check("mult_neg3x7_value", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max_value", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,        "div_neg7by2");
    check("div_neg7by2_value", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1");
    check("div_min_by_m1_value", {m_hi, m_lo}, 64'h0000_0000_8000_0000);
    run_op(MD_DIVU,  32'd7,         32'd0,        "divu_by_zero");

    // 5: ReadReq from RUN cycle 5 stalls until DONE; back-to-back Start.
    start_op(MD_MULT, 32'h1234_5678, 32'h8765_4321);
    finish_op(MD_MULT, 32'h1234_5678, 32'h8765_4321, 1, 6, "readreq_stall");
    start_op(MD_DIVU, 32'hDEAD_BEEF, 32'd13);
    finish_op(MD_DIVU, 32'hDEAD_BEEF, 32'd13, 1, 0, "back_to_back");
    @(negedge Clk);

    // Start while busy is stalled and ignored; the original op completes.
    start_op(MD_MULTU, 32'd1000, 32'd3000);
    @(negedge Clk);
    Start = 1'b1; Op = MD_DIVU; A = 32'd5; B = 32'd0;
    #1;
    check("start_busy_stall", 64'(Stall), 64'(1));
    @(negedge Clk);
    Start = 1'b0;
    finish_op(MD_MULTU, 32'd1000, 32'd3000, 3, 0, "start_busy_ignored");
    @(negedge Clk);

    // Flush wins over Start in IDLE.
    Start = 1'b1; Flush = 1'b1; Op = MD_MULT; A = 32'd9; B = 32'd9;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    #1;
    check("flush_over_start", 64'(Busy), 64'(0));
    @(negedge Clk);

    // 6: Flush at RUN cycle 10 aborts with no Done and no HI/LO change.
    start_op(MD_MULT, 32'hFFFF_0000, 32'h0001_2345);
    repeat (10) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    #1;
    check("flush_idle", {62'(Busy), Done, DivByZero}, 64'(0));
    check("flush_hilo", {Hi, Lo}, {m_hi, m_lo});
    done_seen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'(0));
    check("flush_hilo_later", {Hi, Lo}, {m_hi, m_lo});

    // Reset mid-RUN clears everything immediately.
    start_op(MD_DIV, 32'h7FFF_FFFF, 32'd3);
    repeat (5) @(negedge Clk);
    #2;
    ReadReq = 1'b1;
    Reset   = 1'b1;
    #1;
    check("reset_mid_status", {60'(Busy), Stall, Done, DivByZero}, 64'(0));
    check("reset_mid_hilo", {Hi, Lo}, 64'(0));
    @(negedge Clk);
    Reset = 1'b0; ReadReq = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge Clk);
    #1;
    check("reset_mid_idle", 64'(Busy), 64'(0));

    // Random operations against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) rb = (rop[0]) ? 32'd0 : 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
